rr_arb8_sel: RTL
================

// Module: rr_arb8_sel
// PURPOSE
//   Round-robin arbiter for 8 requesters sharing one 16-bit datapath bus.
//   Drives the 3-bit select of the 8:1 16-bit bus mux (inputs a..h = requesters 0..7).
//   Grants one requester at a time, caps tenure at MAX_HOLD cycles, rotates priority.
//   Registered outputs, so the mux select is glitch-free and changes only on clk.
// PARAMETERS
//   MAX_HOLD  4  max consecutive cycles a requester keeps the grant while others wait (1..255)
// PORTS
//   clk      in   1  system clock, rising edge
//   reset    in   1  asynchronous, active-high reset
//   req      in   8  request per source; bit i = mux input i (0=a .. 7=h)
//   sel      out  3  registered mux select = index of the current/last grantee
//   gnt      out  8  registered one-hot grant; all zero when idle
//   valid    out  1  registered; 1 when gnt != 0 (mux output is owned)
//   gnt_new  out  1  one-cycle pulse on the first cycle of each new grant
// BEHAVIOUR
//   Reset (async, immediate): sel=0, gnt=0, valid=0, gnt_new=0, ptr=0, cnt=0, state=IDLE.
//   Internal state: ptr[2:0] = highest-priority index; cnt[7:0] = tenure counter.
//   Pick(ptr): first i in order ptr, ptr+1, ... ptr+7 (mod 8) with req[i]=1.
//   Every new grant to i: gnt<=1<<i, sel<=i, ptr<=i+1 (7 wraps to 0), cnt<=0, gnt_new<=1.
//   FSM IDLE:
//     - req==0 -> stay; gnt=0, valid=0, sel holds its last value.
//     - req!=0 -> grant Pick(ptr) on the next edge; go to GRANT. Latency req->gnt = 1 clk.
//   FSM GRANT (owner o=sel):
//     - req[o]=0 (release), other reqs present -> grant Pick(ptr) same edge; no bubble.
//     - req[o]=0, no other reqs -> IDLE; gnt<=0, valid<=0, sel holds o.
//     - req[o]=1, cnt<MAX_HOLD-1 -> keep grant; cnt<=cnt+1; gnt_new<=0.
//     - req[o]=1, cnt==MAX_HOLD-1, other reqs present -> forced switch to Pick(ptr).
//       ptr is already o+1, so o is last in priority.
//     - req[o]=1, cnt==MAX_HOLD-1, no other req -> keep o; cnt<=0; no gnt_new pulse.
//   gnt_new=0 on every cycle not starting a new grant.
//   A switch directly from o to a different owner counts as a new grant (pulse=1).
//   Requests are sampled only at clk edges. A requester dropping and raising req
//     between edges is not seen.
//   Invariants: gnt is one-hot or zero; valid == |gnt; when valid=1, gnt == 1<<sel.
//   MAX_HOLD=1: switch every cycle whenever competitors exist.
//   Reset asserted mid-grant: outputs clear asynchronously; after release, first grant
//     starts from index 0.
// TESTING
//   1. reset=1 with req=8'hFF, then release; 1 clk later -> gnt=8'h01, sel=0, valid=1,
//      gnt_new=1.
//   2. req=8'h01 for 3 clks, then 8'h00 -> gnt=01 for 3 clks, then gnt=0, valid=0, sel=0.
//      gnt_new pulses once.
//   3. MAX_HOLD=4, req=8'h81 held constant -> gnt 01 x4, 80 x4, 01 x4.
//      gnt_new pulses at every switch; sel 0,7,0.
//   4. req=8'hFF; each owner drops its req bit 1 clk after being granted ->
//      sel=0,1,...,7,0 with no idle cycle between grants (ptr wrap checked).
//   5. Single requester 8'h20 held 10 clks with MAX_HOLD=4 -> gnt=20 continuously,
//      gnt_new only on the first cycle.
//   6. Assert reset mid-grant (sel=5, cnt=2) between clk edges -> gnt=0, valid=0, sel=0
//      immediately. After release with req=8'h24 -> sel=2 first.
//   Run concurrently through all tests: one-hot/valid/sel invariants, and the
//     combined mux output equals the granted source data.

Source files
------------

// File: rtl/rr_arb8_sel.sv
// rtl/rr_arb8_sel.sv - round-robin arbiter driving the select of an 8:1 16-bit bus mux
// Grants one of 8 requesters with a tenure cap of MAX_HOLD cycles; all outputs registered.
module rr_arb8_sel #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic [7:0] gnt,
  output logic       valid,
  output logic       gnt_new
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state, nstate;
  logic [2:0] ptr, n_ptr, n_sel, pick_idx;
  logic [7:0] cnt, n_cnt, n_gnt, others;
  logic       n_new, take;

  // First requester at or after p in circular order; lowest offset wins.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    pick = p;
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign pick_idx = pick(req, ptr);
  assign others   = req & ~(8'b1 << sel);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      cnt     <= 8'd0;
      sel     <= 3'd0;
      gnt     <= 8'd0;
      valid   <= 1'b0;
      gnt_new <= 1'b0;
    end else begin
      state   <= nstate;
      ptr     <= n_ptr;
      cnt     <= n_cnt;
      sel     <= n_sel;
      gnt     <= n_gnt;
      valid   <= |n_gnt;
      gnt_new <= n_new;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (|req) nstate = GRANT;
      GRANT:   if (req == 8'd0) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    n_gnt = gnt;
    n_sel = sel;
    n_ptr = ptr;
    n_cnt = cnt;
    n_new = 1'b0;
    take  = 1'b0;
    case (state)
      IDLE: begin
        if (|req) take = 1'b1;
        else      n_gnt = 8'd0;
      end
      GRANT: begin
        if (!req[sel]) begin
          if (|req) take = 1'b1;
          else      n_gnt = 8'd0;
        end else if (cnt < HOLD_LAST) begin
          n_cnt = cnt + 8'd1;
        end else if (|others) begin
          // ptr already points past the owner, so the owner ranks last here
          take = 1'b1;
        end else begin
          n_cnt = 8'd0;
        end
      end
      default: n_gnt = 8'd0;
    endcase
    if (take) begin
      n_gnt = 8'b1 << pick_idx;
      n_sel = pick_idx;
      n_ptr = pick_idx + 3'd1;
      n_cnt = 8'd0;
      n_new = 1'b1;
    end
  end

endmodule
